// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw pins and the sample strobe, debounces
// each button on strobe ticks, and emits registered one-cycle press/release pulses.
module button_debouncer #(
  parameter int NUM_BTN        = 5,
  parameter int STABLE_SAMPLES = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_clk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               sample_tick
);

  localparam int CNT_W  = $clog2(STABLE_SAMPLES);
  localparam int MASK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [MASK_W-1:0] MASK_DONE = MASK_W'(SYNC_STAGES + 1);

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] tick_sync_reg;
  logic                   tick_hist_reg;
  logic                   tick_reg;
  logic [MASK_W-1:0]      mask_cnt_reg;

  // The mask hides the rising edge the synchronizer sees when sample_clk is already
  // high at reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_sync_reg <= '0;
      tick_hist_reg <= 1'b0;
      tick_reg      <= 1'b0;
      mask_cnt_reg  <= '0;
    end else begin
      tick_sync_reg <= {tick_sync_reg[SYNC_STAGES-2:0], sample_clk};
      tick_hist_reg <= tick_sync_reg[SYNC_STAGES-1];
      if (mask_cnt_reg != MASK_DONE) begin
        mask_cnt_reg <= mask_cnt_reg + MASK_W'(1);
      end
      tick_reg <= tick_sync_reg[SYNC_STAGES-1] & ~tick_hist_reg &
                  (mask_cnt_reg == MASK_DONE);
    end
  end

  assign sample_tick = tick_reg;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_reg;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   press_reg;
    logic                   release_reg;
    logic                   sample;

    assign sample = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_reg    <= '0;
        state_reg   <= STABLE;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        if (tick_reg) begin
          if (state_reg == STABLE) begin
            if (sample != level_reg) begin
              state_reg <= CONFIRM;
              cnt_reg   <= CNT_W'(1);
            end else begin
              cnt_reg <= '0;
            end
          end else begin
            if (sample == level_reg) begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              // Commit: pulse lands in the same cycle the new level first shows.
              level_reg   <= ~level_reg;
              press_reg   <= ~level_reg;
              release_reg <= level_reg;
              state_reg   <= STABLE;
              cnt_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
      end
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
  end

endmodule
